serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clock_in  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_in  input  1  request to begin one addition; sampled only when not busy.
REQ-005 SHALL have port a_in  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 SHALL have port b_in  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 SHALL have port cin_in  input  1  carry-in; captured on the accepting edge.
REQ-008 SHALL have port busy_out  output  1  high while bits are being processed.
REQ-009 SHALL have port done_out  output  1  one-cycle completion pulse.
REQ-010 SHALL have port sum_out  output  WIDTH  registered result of the last completed addition.
REQ-011 SHALL have port carry_out  output  1  registered carry-out of the last completed addition.

Function
REQ-012 SHALL compute {carry_out,sum_out} = a_in + b_in + cin_in using one 1-bit full-adder slice, reused once per cycle, LSB first.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE: start_in=1 -> capture a_in, b_in into shift registers, carry register <= cin_in, bit counter <= 0, go RUN; start_in=0 -> stay IDLE.
REQ-015 RUN: each edge adds the current LSBs of A and B with the carry register, shifts the sum bit in at the MSB of the partial-sum register, updates the carry, shifts A and B right, increments the counter.
REQ-016 RUN: on the edge processing bit WIDTH-1, load sum_out and carry_out from the completed result, go DONE.
REQ-017 DONE lasts exactly one cycle: done_out=1; start_in=1 -> accept new operands as in IDLE and go RUN; start_in=0 -> go IDLE.
REQ-018 busy_out SHALL be 1 exactly in RUN; done_out SHALL be 1 exactly in DONE; both registered, no combinational path from inputs.
REQ-019 Latency: done_out SHALL rise on the (WIDTH+1)-th rising edge after the edge that accepted start_in.
REQ-020 start_in, a_in, b_in, cin_in SHALL be ignored while in RUN; operand changes during RUN SHALL NOT affect the result.
REQ-021 sum_out and carry_out SHALL hold their previous values throughout RUN and update only on the completion edge (REQ-016); they SHALL hold until the next completion.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH on sum_out; overflow is reported only via carry_out.
REQ-023 Back-to-back operation SHALL sustain one result every WIDTH+1 cycles with start_in held high.

Reset
REQ-024 reset_in=1 at a rising edge SHALL force state IDLE, busy_out=0, done_out=0, sum_out=0, carry_out=0, counter, shift and carry registers = 0.
REQ-025 reset_in SHALL take priority over start_in and over any state transition on the same edge.
REQ-026 Reset during RUN SHALL abort the operation: no done_out pulse for it, and no partial result is ever visible on sum_out.
REQ-027 The first start_in accepted after reset deasserts SHALL behave identically to one accepted after power-up reset.

Verification (WIDTH=8)
REQ-028 Reset for 2 cycles, then release with start_in=0 -> busy_out=0, done_out=0, sum_out=8'h00, carry_out=0 indefinitely.
REQ-029 a_in=8'h0F, b_in=8'h01, cin_in=0, start_in pulsed 1 cycle -> busy_out=1 for 8 cycles, then done_out=1 for 1 cycle on edge 9 with sum_out=8'h10, carry_out=0.
REQ-030 a_in=8'hFF, b_in=8'h01, cin_in=0 -> sum_out=8'h00, carry_out=1; then a_in=8'hFF, b_in=8'hFF, cin_in=1 -> sum_out=8'hFF, carry_out=1.
REQ-031 Start 8'h05+8'h03. During RUN, assert start_in with a_in=8'hAA, b_in=8'h55, cin_in=1 -> ignored. Result: sum_out=8'h08, carry_out=0. Exactly one done_out pulse.
REQ-032 Start 8'h12+8'h34, assert reset_in on the 4th RUN cycle -> next edge: busy_out=0, done_out never pulses, sum_out=8'h00. A new start of 8'h01+8'h01 then yields sum_out=8'h02.
REQ-033 Hold start_in=1 with operands 8'h10+8'h20 then 8'h7F+8'h01 (changed in DONE cycle) -> done_out pulses 9 cycles apart with sum_out=8'h30 then 8'h80, carry_out=0 both.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice reused LSB first, WIDTH
// cycles per addition, registered result and a one-cycle completion pulse.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, psum;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic accept, step, last;
  logic fa_sum, fa_cout;

  // Single full-adder slice shared by every bit position.
  always_comb begin
    fa_sum  = a_sh[0] ^ b_sh[0] ^ carry;
    fa_cout = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start_in) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state     <= IDLE;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      psum      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy_out <= (state_nxt == RUN);
      done_out <= (state_nxt == DONE);
      if (accept) begin
        a_sh  <= a_in;
        b_sh  <= b_in;
        psum  <= '0;
        carry <= cin_in;
        cnt   <= '0;
      end else if (step) begin
        a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
        psum  <= {fa_sum, psum[WIDTH-1:1]};
        carry <= fa_cout;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum_out   <= {fa_sum, psum[WIDTH-1:1]};
          carry_out <= fa_cout;
        end
      end
    end
  end

endmodule
